mac_scheduler: RTL
==================

// Module: mac_scheduler
// PURPOSE
//  Shares one pipelined multiply-add datapath (res = A*B + C, registered) among
//  N requesters. Round-robin arbiter accepts one operand triple per cycle over a
//  valid/ready handshake, drives the MAC inputs and tags each op with its
//  requester ID. It then returns each result with that ID, in issue order.
//  Sits between client blocks and the single MAC instance at datapath top level.
// PARAMETERS
//  N        4  number of requesters (>=1)
//  WIDTH    8  operand width; result width 2*WIDTH
//  MAC_LAT  2  edges from mac_a/b/c registered to mac_res valid (MULT/C stage + sum stage)
//  IDW      $clog2(N) or 1 if N==1: requester ID width (derived, not overridden)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          async reset, active low
//  cfg_en     in   N          per-requester enable; disabled requester never granted
//  req_valid  in   N          requester i presents an op
//  req_ready  out  N          one-hot grant, combinational; transfer = valid & ready
//  req_a      in   N*WIDTH    operand A, slice i for requester i
//  req_b      in   N*WIDTH    operand B
//  req_c      in   N*WIDTH    addend C
//  mac_a      out  WIDTH      operand A to MAC, registered
//  mac_b      out  WIDTH      operand B to MAC, registered
//  mac_c      out  WIDTH      addend C to MAC, registered
//  mac_issue  out  1          mac_a/b/c hold a valid op this cycle
//  mac_res    in   2*WIDTH    MAC result, valid MAC_LAT edges after issue
//  rsp_valid  out  1          response strobe, one cycle, no backpressure
//  rsp_id     out  IDW        requester of this response
//  rsp_data   out  2*WIDTH    A*B+C mod 2^(2*WIDTH)
//  busy       out  1          any op in flight (issue reg or tag pipe)
//  ops_cnt    out  16         completed responses, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst_n=0, async): all outputs 0, req_ready 0, rr pointer 0, tag pipe
//    cleared, ops_cnt 0. In-flight MAC results are discarded and never reported.
//  - Eligible(i) = req_valid[i] & cfg_en[i]. Grant the first eligible index
//    searching ptr, ptr+1 .. wrapping mod N. At most one req_ready bit is high.
//    req_ready is 0 for any non-eligible requester.
//  - On a transfer at edge k:
//    - mac_a/b/c <= granted slices; mac_issue <= 1; ptr <= (grant+1) mod N.
//    - No transfer: mac_issue <= 0, mac_* hold, ptr holds.
//  - Tag pipe: shift register of {valid, id}, depth MAC_LAT+1, loaded at edge k.
//    At edge k+MAC_LAT+1: rsp_valid <= 1, rsp_id <= id, rsp_data <= mac_res.
//    Latency handshake->rsp_valid = MAC_LAT+1 edges.
//  - Throughput 1 op/cycle sustained. Responses stay in issue order; no reordering.
//  - ops_cnt increments on each rsp_valid; it holds at max.
//  - busy = mac_issue | OR(tag valid bits).
//  - req_valid may drop before grant; no op is retained. Operands are sampled
//    only at the transfer edge.
//  - cfg_en change takes effect in the same cycle's arbitration. It does not
//    cancel ops already issued.
//  - N=1: grant = eligible(0) every cycle; ptr constant 0.
// STRUCTURE
//  - mac_sched_pkg: WIDTH/MAC_LAT defaults; typedef struct packed {logic v;
//    logic [IDW-1:0] id;} tag_t; ID-width function.
//  - Sub-module rr_arbiter (N): eligible vector + ptr -> one-hot grant, grant
//    index, any_grant. Pointer register stays in mac_scheduler.
//  - Top holds operand mux, issue regs, tag pipe, response regs, counter.
// TESTING (bench uses behavioural MAC model with MAC_LAT=2, N=4, WIDTH=8)
//  1. Reset: rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, ops_cnt=0.
//     Release -> requester 0 is granted first.
//  2. Req0 only: A=3,B=4,C=5 -> one ready pulse; 3 edges later rsp_valid=1,
//     rsp_id=0, rsp_data=17, ops_cnt=1.
//  3. All 4 valid for 8 cycles -> grants 0,1,2,3,0,1,2,3. Responses follow in
//     the same id order, back-to-back; busy high throughout.
//  4. Max values A=B=C=255 -> rsp_data=16'hFF00. A=0,B=200,C=7 -> 7.
//  5. Issue 2 ops, assert rst_n low 1 edge later -> no rsp_valid ever appears
//     for them; ptr=0 after release.
//  6. cfg_en=4'b1011, all valid -> req_ready[2] never 1; grant order 0,1,3,0,...

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared defaults, tag type and ID-width helper for the MAC scheduler.
package mac_sched_pkg;

   localparam int N_DEF       = 4;
   localparam int WIDTH_DEF   = 8;
   localparam int MAC_LAT_DEF = 2;
   // Tags carry IDs at this fixed width, so up to 2**MAX_IDW requesters fit.
   localparam int MAX_IDW     = 8;

   typedef struct packed {
      logic               v;
      logic [MAX_IDW-1:0] id;
   } tag_t;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Round-robin arbiter: first eligible index at or after ptr, wrapping mod N.
module rr_arbiter
   import mac_sched_pkg::*;
#(
   parameter  int N   = N_DEF,
   localparam int IDW = id_width(N)
) (
   input  logic [N-1:0]   eligible,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant_oh,
   output logic [IDW-1:0] grant_idx,
   output logic           any_grant
);

   logic [IDW-1:0] cand;

   // Scan from the farthest offset back towards ptr so the nearest eligible index wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_oh  = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      cand      = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr) + k) % N);
         if (eligible[cand]) begin
            grant_idx = cand;
            any_grant = 1'b1;
         end
      end
      grant_oh[grant_idx] = any_grant;
   end

endmodule

// File: rtl/mac_scheduler.sv
// Shares one pipelined MAC among N requesters; results return in issue order with their ID.
module mac_scheduler
   import mac_sched_pkg::*;
#(
   parameter  int N       = N_DEF,
   parameter  int WIDTH   = WIDTH_DEF,
   parameter  int MAC_LAT = MAC_LAT_DEF,
   localparam int IDW     = id_width(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       cfg_en,
   input  logic [N-1:0]       req_valid,
   output logic [N-1:0]       req_ready,
   input  logic [N*WIDTH-1:0] req_a,
   input  logic [N*WIDTH-1:0] req_b,
   input  logic [N*WIDTH-1:0] req_c,
   output logic [WIDTH-1:0]   mac_a,
   output logic [WIDTH-1:0]   mac_b,
   output logic [WIDTH-1:0]   mac_c,
   output logic               mac_issue,
   input  logic [2*WIDTH-1:0] mac_res,
   output logic               rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [2*WIDTH-1:0] rsp_data,
   output logic               busy,
   output logic [15:0]        ops_cnt
);

   logic [N-1:0]       eligible, grant_oh;
   logic [IDW-1:0]     grant_idx, ptr_q, ptr_d;
   logic               any_grant, xfer, tags_live;
   logic [WIDTH-1:0]   mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_c_q, mac_c_d;
   logic               mac_issue_q, mac_issue_d;
   tag_t               tag_q [MAC_LAT+1];
   tag_t               tag_d [MAC_LAT+1];
   logic               rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [15:0]        ops_cnt_q, ops_cnt_d;

   assign eligible = req_valid & cfg_en;

   rr_arbiter #(.N(N)) u_arb (
      .eligible  (eligible),
      .ptr       (ptr_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Grants are held off during reset so no requester handshakes into a cleared pipe.
   assign req_ready = grant_oh & {N{rst_n}};
   assign xfer      = any_grant & rst_n;

   always_comb begin
      ptr_d       = ptr_q;
      mac_a_d     = mac_a_q;
      mac_b_d     = mac_b_q;
      mac_c_d     = mac_c_q;
      mac_issue_d = xfer;
      if (xfer) begin
         ptr_d = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
         for (int i = 0; i < N; i++) begin
            if (grant_idx == IDW'(i)) begin
               mac_a_d = req_a[i*WIDTH +: WIDTH];
               mac_b_d = req_b[i*WIDTH +: WIDTH];
               mac_c_d = req_c[i*WIDTH +: WIDTH];
            end
         end
      end

      tag_d[0].v  = xfer;
      tag_d[0].id = MAX_IDW'(grant_idx);
      for (int s = 1; s <= MAC_LAT; s++) tag_d[s] = tag_q[s-1];

      // The last tag stage lines up with the cycle mac_res carries that op's result.
      rsp_valid_d = tag_q[MAC_LAT].v;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      ops_cnt_d   = ops_cnt_q;
      if (tag_q[MAC_LAT].v) begin
         rsp_id_d   = IDW'(tag_q[MAC_LAT].id);
         rsp_data_d = mac_res;
         if (ops_cnt_q != 16'hFFFF) ops_cnt_d = ops_cnt_q + 16'd1;
      end
   end

   always_comb begin
      tags_live = 1'b0;
      for (int s = 0; s <= MAC_LAT; s++) tags_live = tags_live | tag_q[s].v;
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         mac_c_q     <= '0;
         mac_issue_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         ops_cnt_q   <= '0;
         // NOTE: the tag pipe is reset, unlike a plain data array, because its valid bits gate responses.
         for (int s = 0; s <= MAC_LAT; s++) tag_q[s] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         mac_c_q     <= mac_c_d;
         mac_issue_q <= mac_issue_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         ops_cnt_q   <= ops_cnt_d;
         tag_q       <= tag_d;
      end
   end

   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign mac_c     = mac_c_q;
   assign mac_issue = mac_issue_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign ops_cnt   = ops_cnt_q;
   assign busy      = mac_issue_q | tags_live;

endmodule
